// File: rtl/id_branch_ctrl_if.sv
// Bundles the ID-stage branch inputs and the PC-select / hazard-control outputs
// of id_branch_ctrl.
interface id_branch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             rs_eq_rt;
    logic [31:0]      branch_target;
    logic [31:0]      jump_target;
    logic             idex_regwrite;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic             exmem_memread;
    logic [4:0]       exmem_rd;

    logic [1:0]       pc_src;
    logic             stall;
    logic             idex_bubble;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             busy;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] nt_cnt;

    // Pipeline side: drives the decoded instruction and producer status.
    modport master (
        output id_valid, id_opcode, id_rs, id_rt, rs_eq_rt, branch_target, jump_target,
               idex_regwrite, idex_memread, idex_rd, exmem_memread, exmem_rd,
        input  pc_src, stall, idex_bubble, flush, redirect_pc, busy, taken_cnt, nt_cnt
    );

    // Controller side.
    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, rs_eq_rt, branch_target, jump_target,
               idex_regwrite, idex_memread, idex_rd, exmem_memread, exmem_rd,
        output pc_src, stall, idex_bubble, flush, redirect_pc, busy, taken_cnt, nt_cnt
    );
endinterface

// File: rtl/id_branch_ctrl.sv
// ID-stage branch/jump resolution controller: hazard stalls, wrong-path squash, last redirect.
// Optional taken/not-taken statistics are built when ID_BRANCH_STATS_EN is defined.
module id_branch_ctrl #(
    parameter int unsigned ALU_STALL  = 1,
    parameter int unsigned LOAD_STALL = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    id_branch_ctrl_if.slave bus
);
    localparam int unsigned CB = (LOAD_STALL < 2) ? 1 : $clog2(LOAD_STALL + 1);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CB-1:0] cnt, cnt_n;
    logic [CB-1:0] need_rs, need_rt, need;
    logic          is_beq, is_bne, is_jmp, is_br, taken;
    logic          eval;
    logic          resolve_c;
    logic [1:0]    pc_src_c;
    logic          stall_c, bubble_c, flush_c;
    logic [31:0]   redirect_q;

    // Stall cycles owed to one source register; register 0 never hazards.
    function automatic logic [CB-1:0] reg_need(
        input logic [4:0] r,
        input logic       ld,
        input logic       wr,
        input logic [4:0] rd,
        input logic       eld,
        input logic [4:0] erd
    );
        logic [CB-1:0] n;
        n = '0;
        if (r != 5'd0) begin
            if (ld && (rd == r))        n = CB'(LOAD_STALL);
            else if (wr && (rd == r))   n = CB'(ALU_STALL);
            else if (eld && (erd == r)) n = CB'(1);
        end
        return n;
    endfunction

    assign is_beq = (bus.id_opcode == OP_BEQ);
    assign is_bne = (bus.id_opcode == OP_BNE);
    assign is_jmp = (bus.id_opcode == OP_J) || (bus.id_opcode == OP_JAL);
    assign is_br  = is_beq || is_bne;
    assign taken  = (is_beq && bus.rs_eq_rt) || (is_bne && !bus.rs_eq_rt) || is_jmp;

    always_comb begin
        need_rs = reg_need(bus.id_rs, bus.idex_memread, bus.idex_regwrite, bus.idex_rd,
                           bus.exmem_memread, bus.exmem_rd);
        need_rt = reg_need(bus.id_rt, bus.idex_memread, bus.idex_regwrite, bus.idex_rd,
                           bus.exmem_memread, bus.exmem_rd);
        if (!is_br)                 need = '0;
        else if (need_rs > need_rt) need = need_rs;
        else                        need = need_rt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt holds the stall cycles still owed, including the current WAIT cycle,
    // so the first stall (issued from IDLE/RESOLVE) plus WAIT totals exactly `need`.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pc_src_c  = 2'b00;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        resolve_c = 1'b0;
        eval      = 1'b0;

        unique case (state)
            IDLE: begin
                eval = bus.id_valid;
            end
            WAIT: begin
                if (!bus.id_valid) begin
                    state_n = IDLE;
                end else begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_n    = cnt - CB'(1);
                    if (cnt == CB'(1)) state_n = RESOLVE;
                end
            end
            RESOLVE: begin
                state_n = IDLE;
                eval    = bus.id_valid;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (eval) begin
            if (need != '0) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                cnt_n    = need - CB'(1);
                state_n  = (need == CB'(1)) ? RESOLVE : WAIT;
            end else begin
                state_n   = IDLE;
                resolve_c = is_br || is_jmp;
                if (resolve_c && taken) begin
                    pc_src_c = is_jmp ? 2'b10 : 2'b01;
                    flush_c  = 1'b1;
                end
            end
        end

        // Reset silences the Mealy outputs immediately, not just at the next edge.
        if (rst) begin
            pc_src_c  = 2'b00;
            stall_c   = 1'b0;
            bubble_c  = 1'b0;
            flush_c   = 1'b0;
            resolve_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     redirect_q <= 32'd0;
        else if (resolve_c && taken) redirect_q <= is_jmp ? bus.jump_target : bus.branch_target;
    end

`ifdef ID_BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_q, nt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q <= '0;
            nt_q    <= '0;
        end else if (resolve_c) begin
            if (taken)      taken_q <= taken_q + CNT_W'(1);
            else if (is_br) nt_q    <= nt_q + CNT_W'(1);
        end
    end

    assign bus.taken_cnt = taken_q;
    assign bus.nt_cnt    = nt_q;
`else
    assign bus.taken_cnt = '0;
    assign bus.nt_cnt    = '0;
`endif

    assign bus.pc_src      = pc_src_c;
    assign bus.stall       = stall_c;
    assign bus.idex_bubble = bubble_c;
    assign bus.flush       = flush_c;
    assign bus.redirect_pc = redirect_q;
    assign bus.busy        = (state != IDLE);
endmodule
